// File: rtl/byte_to_f36_framer.sv
// Packs a byte stream with end-of-frame marker into 36-bit {flags, data} FIFO words.
// Frames longer than MAX_BYTES are cut short with a forced EOF and the tail is dropped.
module byte_to_f36_framer #(
   parameter int MAX_BYTES = 1514,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [7:0]       data_in,
   input  logic             data_in_en,
   input  logic             data_in_last,
   output logic             data_in_rdy,
   output logic [31:0]      wr_data_o,
   output logic [3:0]       wr_flags_o,
   output logic             wr_src_rdy_o,
   input  logic             wr_dst_rdy_i,
   output logic [CNT_W-1:0] trunc_count,
   output logic             busy
);
   localparam int FB_W = $clog2(MAX_BYTES + 1);
   localparam logic [FB_W-1:0] MAX_FB = FB_W'(MAX_BYTES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DROP  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [23:0]       acc_q, acc_d;
   logic [1:0]        idx_q, idx_d;
   logic [FB_W-1:0]   fb_q, fb_d;
   logic              sof_pend_q, sof_pend_d;
   logic              out_valid_q, out_valid_d;
   logic [31:0]       data_q, data_d;
   logic [3:0]        flags_q, flags_d;
   logic [CNT_W-1:0]  trunc_q, trunc_d;
   logic              busy_q, busy_d;

   logic              accept_s;
   logic              hit_max_s;
   logic              eof_s;
   logic [FB_W-1:0]   fb_inc_s;
   logic [31:0]       word_s;

   // Next-state: packing, framing, truncation and output register handshake
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      fb_d        = fb_q;
      sof_pend_d  = sof_pend_q;
      data_d      = data_q;
      flags_d     = flags_q;
      trunc_d     = trunc_q;
      out_valid_d = out_valid_q;

      // DROP never loads the output register, so it can always swallow bytes
      data_in_rdy = (state_q == DROP) || !out_valid_q || wr_dst_rdy_i;
      accept_s    = data_in_en && data_in_rdy;
      fb_inc_s    = fb_q + FB_W'(1);
      hit_max_s   = (fb_inc_s == MAX_FB);
      eof_s       = data_in_last || hit_max_s;

      word_s = {acc_q, 8'h00};
      case (idx_q)
         2'd0:    word_s[31:24] = data_in;
         2'd1:    word_s[23:16] = data_in;
         2'd2:    word_s[15:8]  = data_in;
         default: word_s[7:0]   = data_in;
      endcase

      if (out_valid_q && wr_dst_rdy_i) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      if (accept_s && (state_q != DROP)) begin
         fb_d    = fb_inc_s;
         state_d = ACCUM;
         if (eof_s || (idx_q == 2'd3)) begin
            out_valid_d = 1'b1;
            data_d      = word_s;
            flags_d     = {(eof_s ? idx_q + 2'd1 : 2'd0), eof_s, sof_pend_q};
            sof_pend_d  = eof_s;
            acc_d       = 24'h000000;
            idx_d       = 2'd0;
         end else begin
            acc_d = word_s[31:8];
            idx_d = idx_q + 2'd1;
         end
         if (data_in_last) begin
            state_d = IDLE;
            fb_d    = '0;
         end else if (hit_max_s) begin
            state_d = DROP;
            fb_d    = '0;
            if (trunc_q != {CNT_W{1'b1}}) begin
               trunc_d = trunc_q + CNT_W'(1);
            end else begin
               trunc_d = trunc_q;
            end
         end else begin
            state_d = ACCUM;
         end
      end else if (accept_s && data_in_last) begin
         state_d = IDLE;
      end else begin
         state_d = state_q;
      end

      busy_d = (state_d != IDLE) || out_valid_d;
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         acc_q       <= 24'h000000;
         idx_q       <= 2'd0;
         fb_q        <= '0;
         sof_pend_q  <= 1'b1;
         out_valid_q <= 1'b0;
         data_q      <= 32'h00000000;
         flags_q     <= 4'h0;
         trunc_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         fb_q        <= fb_d;
         sof_pend_q  <= sof_pend_d;
         out_valid_q <= out_valid_d;
         data_q      <= data_d;
         flags_q     <= flags_d;
         trunc_q     <= trunc_d;
         busy_q      <= busy_d;
      end
   end

   assign wr_data_o    = data_q;
   assign wr_flags_o   = flags_q;
   assign wr_src_rdy_o = out_valid_q;
   assign trunc_count  = trunc_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_byte_to_f36_framer.sv
// Randomized self-checking bench for byte_to_f36_framer against a frame-level packing model.
module tb_byte_to_f36_framer;
   localparam int MAXB = 13;

   logic        clk;
   logic        reset_n;
   logic [7:0]  data_in;
   logic        data_in_en;
   logic        data_in_last;
   logic        data_in_rdy;
   logic [31:0] wr_data_o;
   logic [3:0]  wr_flags_o;
   logic        wr_src_rdy_o;
   logic        wr_dst_rdy_i;
   logic [15:0] trunc_count;
   logic        busy;

   byte_to_f36_framer #(.MAX_BYTES(MAXB), .CNT_W(16)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .data_in      (data_in),
      .data_in_en   (data_in_en),
      .data_in_last (data_in_last),
      .data_in_rdy  (data_in_rdy),
      .wr_data_o    (wr_data_o),
      .wr_flags_o   (wr_flags_o),
      .wr_src_rdy_o (wr_src_rdy_o),
      .wr_dst_rdy_i (wr_dst_rdy_i),
      .trunc_count  (trunc_count),
      .busy         (busy)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   int          dmode    = 0;
   int          exp_trunc = 0;
   int          busy_cnt = 0;
   bit          saw_rdy_low = 0;
   bit          gaps = 0;
   logic [35:0] exp_q[$];
   logic [7:0]  fbuf[0:63];
   bit          prev_stall = 0;
   logic [35:0] prev_word = 36'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Downstream ready pattern
   initial begin
      wr_dst_rdy_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (dmode)
            0:       wr_dst_rdy_i = 1'b1;
            1:       wr_dst_rdy_i = ~wr_dst_rdy_i;
            default: wr_dst_rdy_i = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Output monitor: scoreboard, hold rule, ready rule
   always @(negedge clk) begin
      if (reset_n) begin
         if (busy) busy_cnt++;
         if (!data_in_rdy) saw_rdy_low = 1'b1;
         if (!wr_src_rdy_o || wr_dst_rdy_i) chk("rdy_rule", data_in_rdy, 1);
         if (prev_stall) chk("hold", {wr_src_rdy_o, wr_flags_o, wr_data_o}, {1'b1, prev_word});
         if (wr_src_rdy_o && wr_dst_rdy_i) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(exp_q.size()), 64'd1);
            end else begin
               chk("word", {wr_flags_o, wr_data_o}, exp_q.pop_front());
            end
         end
         prev_stall = wr_src_rdy_o && !wr_dst_rdy_i;
         prev_word  = {wr_flags_o, wr_data_o};
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Frame-level reference: truncate to MAXB, chunk into 4-byte words
   task automatic push_expected(input int len);
      int eff;
      eff = (len > MAXB) ? MAXB : len;
      if (len > MAXB) exp_trunc++;
      for (int w = 0; w * 4 < eff; w++) begin
         int n;
         logic [31:0] d;
         bit eof;
         int occ;
         n = eff - 4 * w;
         if (n > 4) n = 4;
         d = 32'h0;
         for (int k = 0; k < n; k++) d[31 - 8 * k -: 8] = fbuf[4 * w + k];
         eof = (4 * w + n == eff);
         occ = eof ? (n % 4) : 0;
         exp_q.push_back({2'(occ), eof, (w == 0), d});
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int g;
      bit acc;
      g = 0;
      acc = 1'b0;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
         @(posedge clk);
         #1;
      end
      data_in      = b;
      data_in_last = last;
      data_in_en   = 1'b1;
      while (!acc && g < 200) begin
         @(negedge clk);
         acc = data_in_rdy;
         @(posedge clk);
         #1;
         g++;
      end
      data_in_en   = 1'b0;
      data_in_last = 1'b0;
      chk("accept", acc, 1);
      if (!last) chk("busy_in_frame", busy, 1);
   endtask

   task automatic drive_frame(input int len);
      for (int i = 0; i < len; i++) send_byte(fbuf[i], (i == len - 1));
   endtask

   task automatic drain_and_check();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 500) begin
         @(posedge clk);
         g++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("busy_idle", busy, 0);
      chk("src_idle", wr_src_rdy_o, 0);
      chk("trunc", trunc_count, 16'(exp_trunc));
   endtask

   initial begin
      reset_n      = 1'b0;
      data_in      = 8'h00;
      data_in_en   = 1'b0;
      data_in_last = 1'b0;
      #12;
      chk("rst_rdy", data_in_rdy, 1);
      chk("rst_outs", {wr_src_rdy_o, wr_flags_o, wr_data_o, trunc_count, busy}, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;

      // 8 bytes, full ready
      for (int i = 0; i < 8; i++) fbuf[i] = 8'(i + 1);
      exp_q.push_back(36'h1_01020304);
      exp_q.push_back(36'h2_05060708);
      saw_rdy_low = 1'b0;
      drive_frame(8);
      drain_and_check();
      chk("rdy_never_low", saw_rdy_low, 0);

      // 5 bytes
      for (int i = 0; i < 5; i++) fbuf[i] = 8'(8'hA0 + i);
      exp_q.push_back(36'h1_A0A1A2A3);
      exp_q.push_back(36'h6_A4000000);
      drive_frame(5);
      drain_and_check();

      // 1-byte frame
      fbuf[0] = 8'h5A;
      exp_q.push_back(36'h7_5A000000);
      busy_cnt = 0;
      drive_frame(1);
      drain_and_check();
      chk("busy_len_ok", (busy_cnt >= 1 && busy_cnt <= 2), 1);

      // 12 bytes with alternating downstream ready
      dmode = 1;
      for (int i = 0; i < 12; i++) fbuf[i] = 8'($urandom_range(0, 255));
      push_expected(12);
      saw_rdy_low = 1'b0;
      drive_frame(12);
      drain_and_check();
      chk("rdy_deasserted", saw_rdy_low, 1);
      dmode = 0;

      // Over-length frame, then a 4-byte frame
      for (int i = 0; i < 16; i++) fbuf[i] = 8'(8'h10 + i);
      push_expected(16);
      drive_frame(16);
      drain_and_check();
      for (int i = 0; i < 4; i++) fbuf[i] = 8'(8'hC0 + i);
      exp_q.push_back(36'h3_C0C1C2C3);
      drive_frame(4);
      drain_and_check();

      // Exactly MAXB bytes: normal termination
      for (int i = 0; i < MAXB; i++) fbuf[i] = 8'($urandom_range(0, 255));
      push_expected(MAXB);
      drive_frame(MAXB);
      drain_and_check();

      // Reset two bytes into a frame
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_outs", {wr_src_rdy_o, wr_flags_o, wr_data_o, trunc_count, busy}, 0);
      chk("midrst_rdy", data_in_rdy, 1);
      exp_q.delete();
      exp_trunc = 0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) fbuf[i] = 8'(8'h40 + i);
      exp_q.push_back(36'h3_40414243);
      drive_frame(4);
      drain_and_check();

      // Random frames, random ready and input gaps
      gaps = 1'b1;
      for (int f = 0; f < 40; f++) begin
         int len;
         dmode = $urandom_range(0, 2);
         len = $urandom_range(1, 20);
         for (int i = 0; i < len; i++) fbuf[i] = 8'($urandom_range(0, 255));
         push_expected(len);
         drive_frame(len);
         if ($urandom_range(0, 2) == 0) drain_and_check();
      end
      dmode = 2;
      drain_and_check();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
